mux_sequencial: RTL and testbench
=================================

MUX_SEQUENCIAL -- requirements
Module: mux_sequencial

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 Parameter WIDTH, default 1: bit width of each data channel.
REQ-003 Parameter CHANNELS, default 4: number of input channels, legal range 2..16.
REQ-004 Parameter DWELL, default 4: cycles spent on each channel in scan mode, legal range 1..255.
REQ-005 Derived constant SEL_W = ceil(log2(CHANNELS)), minimum 1.
REQ-006 clk  input  1: rising-edge clock.
REQ-007 rst  input  1: asynchronous, active-high reset.
REQ-008 en  input  1: operation enable; low freezes the block.
REQ-009 modo  input  1: 0 = fixed select, 1 = automatic scan.
REQ-010 S  input  SEL_W: channel select, used only in fixed mode.
REQ-011 D  input  CHANNELS*WIDTH: flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-012 Y  output  WIDTH: registered selected data.
REQ-013 canal  output  SEL_W: channel index whose data Y currently holds.
REQ-014 valido  output  1: Y holds a legal sample taken on the previous edge.
REQ-015 fim_ciclo  output  1: one-cycle pulse marking completion of a full scan.

Function
REQ-016 The FSM SHALL have three states: PARADO, FIXO and VARRE.
REQ-017 In any state, en=0 SHALL move the FSM to PARADO.
REQ-018 From PARADO with en=1, the FSM SHALL go to FIXO when modo=0 and to VARRE when modo=1.
REQ-019 Between FIXO and VARRE, the FSM SHALL follow modo on every edge.
REQ-020 In PARADO: Y and canal hold; valido=0; fim_ciclo=0; the channel and dwell counters freeze.
REQ-021 In FIXO, Y SHALL register channel S[SEL_W-1:0], canal SHALL register S, and valido=1, all with one-cycle latency.
REQ-022 In FIXO with S >= CHANNELS, Y and canal SHALL hold and valido SHALL be 0 for that cycle.
REQ-023 On entering VARRE, the channel counter and dwell counter SHALL load 0; the first sample is channel 0.
REQ-024 In VARRE, each edge SHALL register channel[counter] into Y and the counter into canal, with valido=1.
REQ-025 In VARRE, the dwell counter SHALL increment each edge; when it reaches DWELL-1 it SHALL clear and the channel counter SHALL advance.
REQ-026 The channel counter SHALL wrap from CHANNELS-1 to 0; non-power-of-two CHANNELS SHALL never produce an index >= CHANNELS.
REQ-027 fim_ciclo SHALL be 1 for exactly the one cycle after the edge on which the channel counter wraps CHANNELS-1 -> 0; otherwise 0.
REQ-028 A VARRE->FIXO->VARRE sequence SHALL restart the scan at channel 0 without asserting fim_ciclo.
REQ-029 With DWELL=1, the channel SHALL advance on every edge.
REQ-030 D changes in the middle of a dwell SHALL be reflected in Y on the next edge; the block does not latch D per dwell.

Reset
REQ-031 rst=1 SHALL immediately force PARADO, Y=0, canal=0, valido=0, fim_ciclo=0 and both counters to 0, independent of clk.
REQ-032 After rst deasserts, the first edge with en=1 SHALL follow REQ-018, with VARRE starting at channel 0.
REQ-033 Reset asserted mid-scan SHALL discard the scan position; there is no resume.

Structure
REQ-034 Package mux_pkg SHALL hold the state encoding (PARADO=2'd0, FIXO=2'd1, VARRE=2'd2) and the SEL_W computation function.
REQ-035 The dwell counter SHALL be the sub-module contador_permanencia, with inputs clk, rst, clear, en and output terminal-count pulse.
REQ-036 The channel-select multiplexer SHALL be an indexed part-select of D; no per-channel gate instances.

Verification (WIDTH=1, CHANNELS=4, DWELL=4 unless stated)
REQ-037 D=4'b1010, modo=0, S=00,01,10,11 for 20 ns each -> Y=0,1,0,1 one cycle after each S change; valido=1; canal follows S.
REQ-038 D=4'b1010, modo=1 for 16 cycles -> Y=0x4, 1x4, 0x4, 1x4; canal 0..3; fim_ciclo pulses once, on cycle 17.
REQ-039 CHANNELS=3, modo=0, S=11 -> valido=0 and Y holds; modo=1 -> canal sequence 0,1,2,0 with no 3.
REQ-040 Scanning at canal=2 with en dropped for 5 cycles -> Y and canal frozen, valido=0; on en=1 scan resumes at the same dwell count.
REQ-041 rst pulsed between edges mid-scan -> outputs 0 within the same timestep; next scan begins at channel 0.
REQ-042 DWELL=1, WIDTH=8, D={8'hDD,8'hCC,8'hBB,8'hAA} -> Y=AA,BB,CC,DD,AA; fim_ciclo high with the second AA.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the sequential channel multiplexer: FSM encoding
// and the select-width helper used to size channel indices.
package mux_pkg;

    typedef enum logic [1:0] {
        PARADO = 2'd0,
        FIXO   = 2'd1,
        VARRE  = 2'd2
    } estado_t;

    // Width of a channel index; a 2-channel mux still needs one select bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/contador_permanencia.sv
// Dwell counter: counts cycles spent on one scan channel and pulses tc on
// the cycle whose edge completes the dwell. clear has priority over en.
module contador_permanencia #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] r_cnt;

    assign tc = en && !clear && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mux_sequencial.sv
// Registered N-channel multiplexer with a fixed-select mode and an automatic
// scan mode that dwells DWELL cycles per channel and flags each full scan.
module mux_sequencial
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 1,
    parameter  int CHANNELS = 4,
    parameter  int DWELL    = 4,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      modo,
    input  logic [SEL_W-1:0]          S,
    input  logic [CHANNELS*WIDTH-1:0] D,
    output logic [WIDTH-1:0]          Y,
    output logic [SEL_W-1:0]          canal,
    output logic                      valido,
    output logic                      fim_ciclo,
    output estado_t                   o_estado
);

    localparam logic [SEL_W-1:0] ULTIMO   = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]   N_CANAIS = (SEL_W + 1)'(CHANNELS);

    estado_t          r_estado, w_prox;
    logic [WIDTH-1:0] r_y;
    logic [SEL_W-1:0] r_canal, r_cnt;
    logic             r_valido, r_fim, r_armado;

    logic             w_tc, w_clr_perm, w_en_perm;
    logic             w_amostra, w_valido_prox, w_fim_prox, w_armado_prox;
    logic [SEL_W-1:0] w_idx, w_cnt_prox;
    logic [WIDTH-1:0] w_dado;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_estado <= PARADO;
        else     r_estado <= w_prox;
    end

    // en and modo alone pick the next state, whatever the current one is.
    always_comb begin
        w_prox = r_estado;
        if (!en)       w_prox = PARADO;
        else if (modo) w_prox = VARRE;
        else           w_prox = FIXO;
    end

    // r_armado marks a scan in progress: PARADO keeps it so a pause resumes,
    // FIXO and reset drop it so the next scan restarts at channel 0.
    assign w_clr_perm = (w_prox == FIXO) || ((w_prox == VARRE) && !r_armado);
    assign w_en_perm  = (w_prox == VARRE) && r_armado;

    contador_permanencia #(.DWELL(DWELL)) u_perm (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clr_perm),
        .en    (w_en_perm),
        .tc    (w_tc)
    );

    always_comb begin
        w_idx         = r_canal;
        w_cnt_prox    = r_cnt;
        w_amostra     = 1'b0;
        w_valido_prox = 1'b0;
        w_fim_prox    = 1'b0;
        w_armado_prox = r_armado;
        case (w_prox)
            FIXO: begin
                w_cnt_prox    = '0;
                w_armado_prox = 1'b0;
                if ({1'b0, S} < N_CANAIS) begin
                    w_idx         = S;
                    w_amostra     = 1'b1;
                    w_valido_prox = 1'b1;
                end
            end
            VARRE: begin
                w_amostra     = 1'b1;
                w_valido_prox = 1'b1;
                w_armado_prox = 1'b1;
                if (!r_armado) begin
                    w_cnt_prox = '0;
                end else if (w_tc) begin
                    w_cnt_prox = (r_cnt == ULTIMO) ? '0 : r_cnt + SEL_W'(1);
                    w_fim_prox = (r_cnt == ULTIMO);
                end
                w_idx = w_cnt_prox;
            end
            default: ;
        endcase
    end

    // w_idx is always a legal channel here, so the part-select stays in range.
    assign w_dado = D[int'(w_idx)*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y      <= '0;
            r_canal  <= '0;
            r_cnt    <= '0;
            r_valido <= 1'b0;
            r_fim    <= 1'b0;
            r_armado <= 1'b0;
        end else begin
            if (w_amostra) begin
                r_y     <= w_dado;
                r_canal <= w_idx;
            end
            r_cnt    <= w_cnt_prox;
            r_valido <= w_valido_prox;
            r_fim    <= w_fim_prox;
            r_armado <= w_armado_prox;
        end
    end

    assign Y         = r_y;
    assign canal     = r_canal;
    assign valido    = r_valido;
    assign fim_ciclo = r_fim;
    assign o_estado  = r_estado;

endmodule

// File: tb/tb_mux_sequencial.sv
// Bench for mux_sequencial: three configurations (4ch/dwell 4, 3ch, 8-bit
// dwell 1) checked against a table of vectors and hand-built sequences.
module tb_mux_sequencial;
    import mux_pkg::*;

    typedef struct packed {
        logic [7:0] y;
        logic [1:0] canal;
        logic       valido;
        logic       fim;
        logic [1:0] estado;
    } obs_t;

    typedef struct {
        logic       en;
        logic       modo;
        logic [1:0] s;
        logic [3:0] d;
        obs_t       e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, modo = 1'b0;
    logic [1:0]  s = 2'd0;
    logic [3:0]  d_a = 4'd0;
    logic [2:0]  d_b = 3'd0;
    logic [31:0] d_c = 32'd0;

    logic       y_a, y_b;
    logic [7:0] y_c;
    logic [1:0] canal_a, canal_b, canal_c;
    logic       val_a, val_b, val_c, fim_a, fim_b, fim_c;
    logic [1:0] est_a, est_b, est_c;

    obs_t exp_q[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mux_sequencial #(.WIDTH(1), .CHANNELS(4), .DWELL(4)) dut_a (
        .clk(clk), .rst(rst), .en(en), .modo(modo), .S(s), .D(d_a),
        .Y(y_a), .canal(canal_a), .valido(val_a), .fim_ciclo(fim_a), .o_estado(est_a)
    );

    mux_sequencial #(.WIDTH(1), .CHANNELS(3), .DWELL(4)) dut_b (
        .clk(clk), .rst(rst), .en(en), .modo(modo), .S(s), .D(d_b),
        .Y(y_b), .canal(canal_b), .valido(val_b), .fim_ciclo(fim_b), .o_estado(est_b)
    );

    mux_sequencial #(.WIDTH(8), .CHANNELS(4), .DWELL(1)) dut_c (
        .clk(clk), .rst(rst), .en(en), .modo(modo), .S(s), .D(d_c),
        .Y(y_c), .canal(canal_c), .valido(val_c), .fim_ciclo(fim_c), .o_estado(est_c)
    );

    function automatic obs_t mk(input logic [7:0] y, input logic [1:0] c,
                                input logic v, input logic f, input logic [1:0] e);
        obs_t o;
        o.y = y; o.canal = c; o.valido = v; o.fim = f; o.estado = e;
        return o;
    endfunction

    function automatic obs_t observe(input int dut);
        case (dut)
            0:       return mk({7'b0, y_a}, canal_a, val_a, fim_a, est_a);
            1:       return mk({7'b0, y_b}, canal_b, val_b, fim_b, est_b);
            default: return mk(y_c, canal_c, val_c, fim_c, est_c);
        endcase
    endfunction

    task automatic check_out(input int dut, input string name);
        obs_t a, e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = exp_q.pop_front();
        a = observe(dut);
        if (a === e) n_pass++;
        else $display("FAIL %s: got y=%h canal=%0d valido=%b fim=%b estado=%0d, expected y=%h canal=%0d valido=%b fim=%b estado=%0d",
                      name, a.y, a.canal, a.valido, a.fim, a.estado,
                      e.y, e.canal, e.valido, e.fim, e.estado);
    endtask

    task automatic step(input int dut, input obs_t e, input string name);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_out(dut, name);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b1; en = 1'b0; modo = 1'b0; s = 2'd0;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(8'h00, 2'd0, 1'b0, 1'b0, PARADO));
            check_out(k, $sformatf("%s_dut%0d", name, k));
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic build_vecs();
        vec_t v;
        logic [3:0] dv;
        int ch;
        dv = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 2; r++) begin
                v.en = 1'b1; v.modo = 1'b0; v.s = 2'(k); v.d = dv;
                v.e = mk({7'b0, dv[k]}, 2'(k), 1'b1, 1'b0, FIXO);
                vecs.push_back(v);
            end
        end
        for (int i = 1; i <= 17; i++) begin
            ch = ((i - 1) / 4) % 4;
            v.en = 1'b1; v.modo = 1'b1; v.s = 2'd0; v.d = dv;
            v.e = mk({7'b0, dv[ch]}, 2'(ch), 1'b1, (i == 17), VARRE);
            vecs.push_back(v);
        end
        v.en = 1'b0; v.modo = 1'b1; v.s = 2'd0; v.d = dv;
        v.e = mk({7'b0, dv[0]}, 2'd0, 1'b0, 1'b0, PARADO);
        vecs.push_back(v);
        for (int i = 0; i < 10; i++) begin
            v.en = 1'b1; v.modo = 1'b0;
            v.s = 2'($urandom_range(0, 3));
            v.d = 4'($urandom_range(0, 15));
            v.e = mk({7'b0, v.d[v.s]}, v.s, 1'b1, 1'b0, FIXO);
            vecs.push_back(v);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] dv;
        logic [2:0] db;
        int ch;

        build_vecs();
        do_reset("rst0");

        // Fixed select, full scan, pause, random fixed selects.
        for (int i = 0; i < vecs.size(); i++) begin
            en = vecs[i].en; modo = vecs[i].modo; s = vecs[i].s; d_a = vecs[i].d;
            step(0, vecs[i].e, $sformatf("vec%0d", i));
        end

        // Pause at channel 2 mid-dwell, then resume at the same dwell count.
        do_reset("rst1");
        dv = 4'b0110; d_a = dv; en = 1'b1; modo = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            ch = (i - 1) / 4;
            step(0, mk({7'b0, dv[ch]}, 2'(ch), 1'b1, 1'b0, VARRE), $sformatf("pre_pause%0d", i));
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++)
            step(0, mk({7'b0, dv[2]}, 2'd2, 1'b0, 1'b0, PARADO), $sformatf("pause%0d", i));
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ch = (i < 2) ? 2 : (i < 6) ? 3 : 0;
            step(0, mk({7'b0, dv[ch]}, 2'(ch), 1'b1, (i == 6), VARRE), $sformatf("resume%0d", i));
        end

        // Reset pulsed between edges mid-scan.
        do_reset("rst2");
        dv = 4'b0010; d_a = dv; en = 1'b1; modo = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            ch = (i - 1) / 4;
            step(0, mk({7'b0, dv[ch]}, 2'(ch), 1'b1, 1'b0, VARRE), $sformatf("pre_rst%0d", i));
        end
        #3 rst = 1'b1;
        #1;
        exp_q.push_back(mk(8'h00, 2'd0, 1'b0, 1'b0, PARADO));
        check_out(0, "async_rst");
        #1 rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            ch = (i - 1) / 4;
            step(0, mk({7'b0, dv[ch]}, 2'(ch), 1'b1, 1'b0, VARRE), $sformatf("post_rst%0d", i));
        end

        // Three channels: out-of-range select, then scan without index 3.
        do_reset("rst3");
        db = 3'b101; d_b = db; en = 1'b1; modo = 1'b0; s = 2'd1;
        step(1, mk(8'h00, 2'd1, 1'b1, 1'b0, FIXO), "c3_s1");
        s = 2'd3;
        step(1, mk(8'h00, 2'd1, 1'b0, 1'b0, FIXO), "c3_s3a");
        step(1, mk(8'h00, 2'd1, 1'b0, 1'b0, FIXO), "c3_s3b");
        s = 2'd2;
        step(1, mk(8'h01, 2'd2, 1'b1, 1'b0, FIXO), "c3_s2");
        modo = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            ch = ((i - 1) / 4) % 3;
            step(1, mk({7'b0, db[ch]}, 2'(ch), 1'b1, (i == 13), VARRE), $sformatf("c3_scan%0d", i));
        end

        // DWELL=1, 8-bit data, then VARRE->FIXO->VARRE restart.
        do_reset("rst4");
        d_c = {8'hDD, 8'hCC, 8'hBB, 8'hAA}; en = 1'b1; modo = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ch = i % 4;
            step(2, mk(d_c[8*ch +: 8], 2'(ch), 1'b1, (i == 4), VARRE), $sformatf("d1_scan%0d", i));
        end
        modo = 1'b0; s = 2'd3;
        step(2, mk(8'hDD, 2'd3, 1'b1, 1'b0, FIXO), "d1_fixo");
        modo = 1'b1;
        step(2, mk(8'hAA, 2'd0, 1'b1, 1'b0, VARRE), "d1_restart0");
        step(2, mk(8'hBB, 2'd1, 1'b1, 1'b0, VARRE), "d1_restart1");

        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
